int_fp_acc: RTL and testbench
=============================

# int_fp_acc

Accumulation stage placed directly downstream of the shared INT8/FP16 multiplier; consumes its 16-bit products one per beat and reduces each group of beats (delimited by `in_last`) to a single sum. INT mode sums two's-complement int16 products into a wide register. FP16 mode sums IEEE half-precision products through a combinational FP16 adder. Results leave on a valid/ready port together with a sticky error flag and the beat count.

## Interface
- `ACC_W`, default 32: INT accumulator width, at least 17.
- `CNT_W`, default 8: beat-counter width; the counter saturates.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mode` input 1: 1 = FP16, 0 = INT; sampled on the first accepted beat of each group.
- `in_valid` input 1: product beat valid.
- `in_ready` output 1: stage can accept a beat.
- `in_data` input 16: product; int16 two's complement or FP16.
- `in_last` input 1: beat closes the group.
- `in_error` input 1: multiplier error for this beat; FP mode only.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output ACC_W: INT sum, or `{zeros, fp16}` in FP mode.
- `out_error` output 1: sticky error over the group.
- `out_count` output CNT_W: number of beats in the group, saturating.

## Operation
- A beat is accepted when `in_valid && in_ready`; a result is taken when `out_valid && out_ready`.
- States:
  - IDLE: accumulator zero, no group open.
  - ACC: group open.
  - HOLD: result presented.
- Transitions:
  - IDLE to ACC on an accepted beat without `in_last`.
  - IDLE or ACC to HOLD on an accepted beat with `in_last`.
  - HOLD to IDLE on `out_ready`.
  - Every other condition holds the current state.
- `in_ready` = (state != HOLD). There is no bypass: no beat is accepted while a result is held.
- First beat of a group:
  - latch `mode` into `grp_mode`;
  - accumulator = 0 + beat;
  - count = 1;
  - err = `in_error & mode`.
- Later beats in the group: accumulator += beat, count = min(count+1, 2^CNT_W−1), err |= new error. A `mode` change mid-group is ignored.
- INT arithmetic:
  - sign-extend `in_data` to ACC_W and add modulo 2^ACC_W;
  - signed overflow (operands share a sign, result sign differs) sets err, and the sum wraps.
- FP arithmetic (sub-module `fp16_add`):
  - subnormal operands flush to zero;
  - align the smaller operand by right shift with truncation; no rounding, which matches the multiplier;
  - effective subtract of equal magnitudes gives +0;
  - a result exponent above 30 gives ±Inf (0x7C00 or 0xFC00) and sets err;
  - a result underflowing below the minimum normal gives signed zero, with no error;
  - any Inf operand propagates as Inf with err set.
- In HOLD:
  - `out_data`, `out_error` and `out_count` come from registers and stay stable until taken;
  - on take, the accumulator, count and err clear.

## Timing
- Reset values:
  - state = IDLE;
  - accumulator = 0;
  - count = 0;
  - err = 0;
  - `out_valid` = 0, `out_data` = 0, `out_error` = 0, `out_count` = 0;
  - `in_ready` = 1 once reset is deasserted.
- Latency: `out_valid` rises in the cycle after the `in_last` beat is accepted.
- Throughput: one beat per cycle within a group. An N-beat group occupies N cycles plus at least 1 HOLD cycle.
- A beat offered while in HOLD waits. `in_valid` may stay high across HOLD; the beat is accepted in the first IDLE cycle.
- `out_valid` stays high until taken, with no combinational path from `out_ready` to `out_valid`.
- `in_ready` depends on state only; it is not driven combinationally from `out_ready`.
- Reset mid-group or in HOLD discards everything immediately and asynchronously.
- A single-beat group (`in_last` on the first beat) returns sum = beat and count = 1.

## Structure
- Shared package holds:
  - state encoding (IDLE/ACC/HOLD);
  - FP16 field constants: exponent width 5, mantissa width 10, bias 15, EXP_MAX 31, Inf pattern 0x7C00.
- Sub-module `fp16_add`:
  - combinational;
  - ports a[15:0], b[15:0], sum[15:0], ovf;
  - reusable by later MAC stages.
- Top module holds the FSM, the INT adder, the counter and the output registers.

## Test plan
- INT, beats 0x0005, 0xFFFD, 0x0010 (last) → out_data 0x00000012, out_count 3, out_error 0.
- FP, beats 0x3C00, 0x3C00 (last) → out_data[15:0] 0x4000, error 0. Next group 0x0001, 0x3C00 (last) → 0x3C00, because the subnormal flushes.
- FP overflow, beats 0x7BFF, 0x7BFF (last) → 0x7C00, out_error 1. The next group, 0x3C00 (last), returns error 0.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable. When `out_ready`=1, the pending beat is accepted in the following cycle.
- Mode latch: group starts INT and `mode` toggles to 1 mid-group → the sum is computed as INT. A 300-beat group reports out_count 255.
- Reset asserted in ACC after 2 beats → all outputs 0 and state IDLE. The next single beat 0x0007 (last) → out_data 0x00000007, out_count 1.

Source files
------------

// File: rtl/int_fp_acc_pkg.sv
// Shared definitions for the INT/FP16 product accumulator: FSM encoding,
// FP16 field constants and a leading-zero helper for normalisation.
package int_fp_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } acc_state_e;

  localparam int          FP_EXP_W   = 5;
  localparam int          FP_MAN_W   = 10;
  localparam int          FP_BIAS    = 15;
  localparam int          FP_EXP_MAX = 31;
  localparam logic [15:0] FP_INF     = 16'h7C00;

  // Leading zeros of an 11-bit significand; 11 when the value is zero.
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd11;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(10 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder: flush-to-zero inputs, truncating alignment and
// normalisation, saturation to signed Inf with ovf on overflow or Inf input.
module fp16_add
  import int_fp_acc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        ovf
);

  localparam int MW = FP_MAN_W;
  localparam int EW = FP_EXP_W;

  logic          sa, sb, a_inf, b_inf, swap;
  logic          s_big, s_small;
  logic [EW-1:0] ea, eb, e_big, e_small, d;
  logic [MW:0]   ma, mb, m_big, m_small, m_shr, m_sub;
  logic [MW+1:0] m_add;
  logic [MW-1:0] m_norm;
  logic [3:0]    lz;
  logic [EW:0]   e_inc;

  always_comb begin
    sa    = a[15];
    sb    = b[15];
    ea    = a[14:10];
    eb    = b[14:10];
    a_inf = (ea == EW'(FP_EXP_MAX));
    b_inf = (eb == EW'(FP_EXP_MAX));
    // subnormals carry no implicit one and are treated as zero
    ma    = (ea == '0) ? '0 : {1'b1, a[9:0]};
    mb    = (eb == '0) ? '0 : {1'b1, b[9:0]};

    swap    = ({eb, mb} > {ea, ma});
    s_big   = swap ? sb : sa;
    s_small = swap ? sa : sb;
    e_big   = swap ? eb : ea;
    e_small = swap ? ea : eb;
    m_big   = swap ? mb : ma;
    m_small = swap ? ma : mb;

    d      = e_big - e_small;
    m_shr  = (d > EW'(MW)) ? '0 : (m_small >> d);
    m_add  = {1'b0, m_big} + {1'b0, m_shr};
    m_sub  = m_big - m_shr;
    lz     = lzc11(m_sub);
    m_norm = MW'(m_sub << lz);
    e_inc  = {1'b0, e_big} + (EW+1)'(1);

    sum = '0;
    ovf = 1'b0;
    if (a_inf || b_inf) begin
      sum = {a_inf ? sa : sb, 15'b0} | FP_INF;
      ovf = 1'b1;
    end else if (m_big == '0) begin
      sum = '0;
    end else if (s_big == s_small) begin
      if (m_add[MW+1]) begin
        if (e_inc > (EW+1)'(FP_EXP_MAX - 1)) begin
          sum = {s_big, 15'b0} | FP_INF;
          ovf = 1'b1;
        end else begin
          sum = {s_big, e_inc[EW-1:0], m_add[MW:1]};
        end
      end else begin
        sum = {s_big, e_big, m_add[MW-1:0]};
      end
    end else begin
      // equal magnitudes cancel to +0; results below min normal go to signed zero
      if (m_sub == '0) begin
        sum = '0;
      end else if ({1'b0, e_big} <= {2'b0, lz}) begin
        sum = {s_big, 15'b0};
      end else begin
        sum = {s_big, e_big - EW'(lz), m_norm};
      end
    end
  end

endmodule

// File: rtl/int_fp_acc.sv
// Group accumulator behind the shared INT8/FP16 multiplier: sums beats up to
// in_last in INT or FP16 mode and presents the result on a valid/ready port.
module int_fp_acc
  import int_fp_acc_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  input  logic             in_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_error,
  output logic [CNT_W-1:0] out_count
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_data_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q;
  logic             err_q, err_d, out_error_q, grp_mode_q;
  logic             beat_acc, take, first, eff_mode;
  logic [ACC_W-1:0] int_a, int_b, int_sum;
  logic             int_ovf;
  logic [15:0]      fp_a, fp_sum;
  logic             fp_ovf;

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign beat_acc  = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign first     = (state_q == ST_IDLE);
  // mode only matters on the opening beat; afterwards the latched copy rules
  assign eff_mode  = first ? mode : grp_mode_q;

  assign int_a   = first ? '0 : acc_q;
  assign int_b   = {{(ACC_W-16){in_data[15]}}, in_data};
  assign int_sum = int_a + int_b;
  assign int_ovf = (int_a[ACC_W-1] == int_b[ACC_W-1]) &&
                   (int_sum[ACC_W-1] != int_a[ACC_W-1]);

  assign fp_a = first ? 16'h0000 : acc_q[15:0];

  fp16_add u_fp_add (
    .a   (fp_a),
    .b   (in_data),
    .sum (fp_sum),
    .ovf (fp_ovf)
  );

  always_comb begin
    acc_d = eff_mode ? {{(ACC_W-16){1'b0}}, fp_sum} : int_sum;
    cnt_d = first ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    err_d = (first ? 1'b0 : err_q) | (in_error & eff_mode) |
            (eff_mode ? fp_ovf : int_ovf);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACC: if (beat_acc) state_d = in_last ? ST_HOLD : ST_ACC;
      ST_HOLD:         if (out_ready) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      grp_mode_q  <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        acc_q <= '0;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (beat_acc) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        err_q <= err_d;
        if (first) grp_mode_q <= mode;
        if (in_last) begin
          out_data_q  <= acc_d;
          out_count_q <= cnt_d;
          out_error_q <= err_d;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_error = out_error_q;

endmodule

// File: tb/tb_int_fp_acc.sv
// Directed bench for int_fp_acc: expected group results are queued as beats
// are driven and checked when the accumulator presents them.
module tb_int_fp_acc;

  localparam int ACC_W = 20;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             in_error = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, out_error;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  int_fp_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_error  (in_error),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_error (out_error),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_res(input logic [ACC_W-1:0] d, input logic [CNT_W-1:0] c, input logic e);
    exp_t x;
    x.data = d;
    x.cnt  = c;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic [15:0] d, input logic m, input logic l, input logic e);
    int t = 0;
    in_valid = 1'b1; in_data = d; mode = m; in_last = l; in_error = e;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready observed 0 expected 1");
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0;
  endtask

  task automatic get_result(input string tag);
    exp_t x;
    int   t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    x = exp_q.pop_front();
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: out_valid observed 0 expected 1", tag);
    end else begin
      check({tag, ".data"}, 32'(out_data), 32'(x.data));
      check({tag, ".count"}, 32'(out_count), 32'(x.cnt));
      check({tag, ".error"}, 32'(out_error), 32'(x.err));
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_data", 32'(out_data), 0);
    check("rst.out_count", 32'(out_count), 0);
    check("rst.out_error", 32'(out_error), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 1);

    // INT basic sum, with latency check on the closing beat
    send(16'h0005, 1'b0, 1'b0, 1'b0);
    send(16'hFFFD, 1'b0, 1'b0, 1'b0);
    expect_res(20'h00012, 8'd3, 1'b0);
    send(16'h0010, 1'b0, 1'b1, 1'b0);
    check("int_basic.latency", 32'(out_valid), 1);
    get_result("int_basic");

    // INT negative sum sign-extends
    send(16'hFFFD, 1'b0, 1'b0, 1'b0);
    expect_res(20'hFFFFB, 8'd2, 1'b0);
    send(16'hFFFE, 1'b0, 1'b1, 1'b0);
    get_result("int_neg");

    // FP 1.0 + 1.0
    send(16'h3C00, 1'b1, 1'b0, 1'b0);
    expect_res(20'h04000, 8'd2, 1'b0);
    send(16'h3C00, 1'b1, 1'b1, 1'b0);
    get_result("fp_add");

    // FP subnormal flushes
    send(16'h0001, 1'b1, 1'b0, 1'b0);
    expect_res(20'h03C00, 8'd2, 1'b0);
    send(16'h3C00, 1'b1, 1'b1, 1'b0);
    get_result("fp_flush");

    // FP overflow to +Inf sets error, next group starts clean
    send(16'h7BFF, 1'b1, 1'b0, 1'b0);
    expect_res(20'h07C00, 8'd2, 1'b1);
    send(16'h7BFF, 1'b1, 1'b1, 1'b0);
    get_result("fp_ovf");
    expect_res(20'h03C00, 8'd1, 1'b0);
    send(16'h3C00, 1'b1, 1'b1, 1'b0);
    get_result("fp_after_ovf");

    // FP in_error is sticky across the group
    send(16'h3C00, 1'b1, 1'b0, 1'b1);
    expect_res(20'h04000, 8'd2, 1'b1);
    send(16'h3C00, 1'b1, 1'b1, 1'b0);
    get_result("fp_in_err");

    // FP equal magnitudes cancel to +0
    send(16'h4000, 1'b1, 1'b0, 1'b0);
    expect_res(20'h00000, 8'd2, 1'b0);
    send(16'hC000, 1'b1, 1'b1, 1'b0);
    get_result("fp_cancel");

    // FP 2.0 - 1.0 renormalises
    send(16'h4000, 1'b1, 1'b0, 1'b0);
    expect_res(20'h03C00, 8'd2, 1'b0);
    send(16'hBC00, 1'b1, 1'b1, 1'b0);
    get_result("fp_sub");

    // FP carry-out drops the low bit by truncation
    send(16'h3C03, 1'b1, 1'b0, 1'b0);
    expect_res(20'h04001, 8'd2, 1'b0);
    send(16'h3C00, 1'b1, 1'b1, 1'b0);
    get_result("fp_trunc");

    // FP result below min normal gives signed zero, no error
    send(16'h8401, 1'b1, 1'b0, 1'b0);
    expect_res(20'h08000, 8'd2, 1'b0);
    send(16'h0400, 1'b1, 1'b1, 1'b0);
    get_result("fp_underflow");

    // mode latched on first beat; in_error ignored in INT
    send(16'h0002, 1'b0, 1'b0, 1'b0);
    send(16'h3C00, 1'b1, 1'b0, 1'b1);
    expect_res(20'h03C03, 8'd3, 1'b0);
    send(16'h0001, 1'b1, 1'b1, 1'b1);
    get_result("mode_latch");

    // INT signed overflow wraps and flags error: 17 * 0x7FFF
    for (int i = 0; i < 16; i++) send(16'h7FFF, 1'b0, 1'b0, 1'b0);
    expect_res(20'h87FEF, 8'd17, 1'b1);
    send(16'h7FFF, 1'b0, 1'b1, 1'b0);
    get_result("int_ovf");

    // count saturates at 255 for a 300-beat group
    for (int i = 0; i < 299; i++) send(16'h0001, 1'b0, 1'b0, 1'b0);
    expect_res(20'h0012C, 8'd255, 1'b0);
    send(16'h0001, 1'b0, 1'b1, 1'b0);
    get_result("cnt_sat");

    // backpressure: result held, pending beat waits
    send(16'h0001, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 16'h0007; mode = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.in_ready", 32'(in_ready), 0);
      check("bp.out_valid", 32'(out_valid), 1);
      check("bp.out_data", 32'(out_data), 1);
      check("bp.out_count", 32'(out_count), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.taken_valid", 32'(out_valid), 0);
    check("bp.taken_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("bp.pending_accepted", 32'(out_valid), 1);
    expect_res(20'h00007, 8'd1, 1'b0);
    get_result("bp_pending");

    // asynchronous reset in ACC discards the partial group
    send(16'h0003, 1'b0, 1'b0, 1'b0);
    send(16'h0004, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.out_data", 32'(out_data), 0);
    check("arst.out_count", 32'(out_count), 0);
    check("arst.out_error", 32'(out_error), 0);
    check("arst.in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_res(20'h00007, 8'd1, 1'b0);
    send(16'h0007, 1'b0, 1'b1, 1'b0);
    get_result("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
